// File: rtl/neural_pkg.sv
// Shared types for the sample fetch path: Q16.16 words, record layout,
// FIFO entry and fetch FSM encoding.
package neural_pkg;

  typedef logic signed [31:0] fixed_t;   // Q16.16

  localparam int REC_WORDS = 5;
  localparam int HDR_WORDS = 2;

  // {target, in3, in2, in1, in0}; in0 lands at bits [31:0]
  typedef struct packed {
    fixed_t       target;
    fixed_t [3:0] in;
  } record_t;

  typedef struct packed {
    record_t rec;
    logic    last;
    logic    fin;
  } fifo_entry_t;

  typedef enum logic [2:0] {
    HDR0, HDR1, IDLE, TRAIN, TEST, DRAIN
  } fetch_state_t;

  // word address of record idx (train and test records share one numbering)
  function automatic logic [15:0] rec_base(input logic [15:0] idx);
    return 16'(HDR_WORDS) + 16'(REC_WORDS) * idx;
  endfunction

endpackage

// File: rtl/sample_fetch_unit_record_fifo.sv
// Synchronous FIFO of assembled records with their last/final flags.
// Push on a full FIFO is accepted only when a pop happens in the same cycle.
module record_fifo
  import neural_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fifo_entry_t              wdata,
  input  logic                     pop,
  output fifo_entry_t              rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // storage array, no reset needed: head is only observed when not empty
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;

  // pointers and occupancy
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end

endmodule

// File: rtl/sample_fetch_unit.sv
// Sample fetch unit: loads the dataset header, then streams training
// records (EPOCHS passes) or a single test record from word memory into
// a record FIFO presented on a valid/ready port.
module sample_fetch_unit
  import neural_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUT    = 2,
  parameter int EPOCHS     = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_train,
  input  logic              start_test,
  input  logic [7:0]        test_sel,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              hdr_valid,
  output logic [7:0]        num_train,
  output logic [7:0]        num_test,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [159:0]      rec_data,
  output logic              rec_last,
  output logic              rec_final,
  output logic              busy,
  output logic              sel_err
);

  localparam int CAP = REC_WORDS * FIFO_DEPTH;   // words the FIFO can absorb

  fetch_state_t state, state_n;

  logic        boot;          // one cycle after reset, so mem_req is 0 in reset
  logic        hdr_issued;    // header word requested, waiting for its data
  logic        train_mode;

  // issue side
  logic [15:0] addr_q;
  logic [2:0]  w_cnt;
  logic [7:0]  r_cnt;
  logic [15:0] e_cnt;
  logic [7:0]  out_cnt;

  // receive side
  logic [2:0]   rx_w;
  logic [7:0]   rx_r;
  logic [15:0]  rx_e;
  fixed_t [3:0] asm_words;

  logic        gnt_ok, can_issue, issue_done;
  logic        w_last, r_last, e_last;
  logic        go_train, go_test, bad_sel;
  logic        rx_active, rx_rec_last, rx_rec_final;
  logic [15:0] inflight;

  logic                       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  fifo_entry_t                fifo_wdata, fifo_rdata;

  assign gnt_ok   = mem_req && mem_gnt;
  assign w_last   = (w_cnt == 3'd4);
  assign r_last   = (r_cnt == num_train - 8'd1);
  assign e_last   = (e_cnt == 16'(EPOCHS - 1));
  assign issue_done = gnt_ok && w_last && (state == TEST || (r_last && e_last));

  assign go_train = (state == IDLE) && start_train && (num_train != 8'd0);
  assign go_test  = (state == IDLE) && !start_train && start_test && (test_sel < num_test);
  assign bad_sel  = (state == IDLE) && !start_train && start_test && (test_sel >= num_test);

  // Words requested but not yet sitting in the FIFO, plus words the FIFO
  // already holds; one more request is allowed only if that total still fits.
  assign inflight  = 16'(out_cnt) + 16'(rx_w) + 16'(REC_WORDS) * 16'(fifo_count);
  assign can_issue = (out_cnt < 8'(MAX_OUT)) && (inflight < 16'(CAP));

  assign rx_active    = mem_rvalid && (state == TRAIN || state == TEST || state == DRAIN);
  assign rx_rec_last  = train_mode ? (rx_r == num_train - 8'd1) : 1'b1;
  assign rx_rec_final = train_mode ? (rx_rec_last && rx_e == 16'(EPOCHS - 1)) : 1'b1;

  assign fifo_wdata.rec.target = mem_rdata;
  assign fifo_wdata.rec.in     = asm_words;
  assign fifo_wdata.last       = rx_rec_last;
  assign fifo_wdata.fin        = rx_rec_final;
  // credit accounting guarantees a free slot; the full check keeps the head intact regardless
  assign fifo_push = rx_active && (rx_w == 3'd4) && (!fifo_full || fifo_pop);
  assign fifo_pop  = rec_valid && rec_ready;

  assign rec_valid = !fifo_empty;
  assign rec_data  = rec_valid ? fifo_rdata.rec  : '0;
  assign rec_last  = rec_valid && fifo_rdata.last;
  assign rec_final = rec_valid && fifo_rdata.fin;

  assign busy = (state == TRAIN) || (state == TEST) ||
                ((state == DRAIN) && !(out_cnt == 8'd0 && fifo_empty));

  record_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= HDR0;
    else     state <= state_n;

  // next state and memory request
  always_comb begin
    state_n  = state;
    mem_req  = 1'b0;
    mem_addr = ADDR_W'(addr_q);
    unique case (state)
      HDR0: begin
        mem_req  = boot && !hdr_issued;
        mem_addr = '0;
        if (mem_rvalid) state_n = HDR1;
      end
      HDR1: begin
        mem_req  = !hdr_issued;
        mem_addr = ADDR_W'(1);
        if (mem_rvalid) state_n = IDLE;
      end
      IDLE: begin
        if (go_train)     state_n = TRAIN;
        else if (go_test) state_n = TEST;
      end
      TRAIN, TEST: begin
        mem_req = can_issue;
        if (issue_done) state_n = DRAIN;
      end
      DRAIN: if (out_cnt == 8'd0 && fifo_empty) state_n = IDLE;
      default: state_n = HDR0;
    endcase
  end

  // header load, outstanding count, select-error pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      boot       <= 1'b0;
      hdr_issued <= 1'b0;
      hdr_valid  <= 1'b0;
      num_train  <= '0;
      num_test   <= '0;
      out_cnt    <= '0;
      sel_err    <= 1'b0;
    end else begin
      boot    <= 1'b1;
      out_cnt <= out_cnt + 8'(gnt_ok) - 8'(mem_rvalid);
      sel_err <= bad_sel;
      if ((state == HDR0 || state == HDR1) && gnt_ok) hdr_issued <= 1'b1;
      if (state == HDR0 && mem_rvalid) begin
        num_train  <= mem_rdata[7:0];
        hdr_issued <= 1'b0;
      end
      if (state == HDR1 && mem_rvalid) begin
        num_test   <= mem_rdata[7:0];
        hdr_issued <= 1'b0;
        hdr_valid  <= 1'b1;
      end
    end

  // address generation: word / record / epoch counters advance per grant
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q <= '0;
      w_cnt  <= '0;
      r_cnt  <= '0;
      e_cnt  <= '0;
    end else if (go_train) begin
      addr_q <= 16'(HDR_WORDS);
      w_cnt  <= '0;
      r_cnt  <= '0;
      e_cnt  <= '0;
    end else if (go_test) begin
      addr_q <= rec_base(16'(num_train) + 16'(test_sel));
      w_cnt  <= '0;
    end else if (gnt_ok && (state == TRAIN || state == TEST)) begin
      if (w_last) begin
        w_cnt <= '0;
        if (state == TRAIN && r_last) begin
          r_cnt  <= '0;
          e_cnt  <= e_cnt + 16'd1;
          addr_q <= 16'(HDR_WORDS);
        end else begin
          r_cnt  <= r_cnt + 8'd1;
          addr_q <= addr_q + 16'd1;
        end
      end else begin
        w_cnt  <= w_cnt + 3'd1;
        addr_q <= addr_q + 16'd1;
      end
    end

  // record assembler: gathers in0..in3, fifth word completes the push;
  // its own record/epoch counters derive the last/final flags in return order
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_w       <= '0;
      rx_r       <= '0;
      rx_e       <= '0;
      train_mode <= 1'b0;
      asm_words  <= '0;
    end else if (go_train || go_test) begin
      rx_w       <= '0;
      rx_r       <= '0;
      rx_e       <= '0;
      train_mode <= go_train;
    end else if (rx_active) begin
      if (rx_w == 3'd4) begin
        rx_w <= '0;
        if (rx_rec_last) begin
          rx_r <= '0;
          rx_e <= rx_e + 16'd1;
        end else begin
          rx_r <= rx_r + 8'd1;
        end
      end else begin
        asm_words[rx_w[1:0]] <= mem_rdata;
        rx_w <= rx_w + 3'd1;
      end
    end

endmodule

// File: tb/tb_sample_fetch_unit.sv
// Directed + randomized bench for sample_fetch_unit with a memory responder,
// a queue-based reference of expected addresses and records, and a consumer checker.
module tb_sample_fetch_unit;
  import neural_pkg::*;

  localparam int EP    = 2;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_train = 1'b0, start_test = 1'b0;
  logic [7:0]   test_sel = '0;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         hdr_valid;
  logic [7:0]   num_train, num_test;
  logic         rec_valid, rec_ready = 1'b0;
  logic [159:0] rec_data;
  logic         rec_last, rec_final, busy, sel_err;

  sample_fetch_unit #(.ADDR_W(32), .FIFO_DEPTH(DEPTH), .MAX_OUT(MAXO), .EPOCHS(EP)) dut (
    .clk(clk), .rst(rst), .start_train(start_train), .start_test(start_test),
    .test_sel(test_sel), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .hdr_valid(hdr_valid),
    .num_train(num_train), .num_test(num_test), .rec_valid(rec_valid),
    .rec_ready(rec_ready), .rec_data(rec_data), .rec_last(rec_last),
    .rec_final(rec_final), .busy(busy), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fails = 0;

  typedef struct { logic [31:0] addr; int due; } pend_t;

  logic [31:0]  mem [256];
  pend_t        pend[$];
  logic [31:0]  exp_addr[$];
  logic [161:0] exp_rec[$];
  int cyc = 0, max_dly = 0, gwait = 0, outst = 0, gnt_cnt = 0, pop_cnt = 0;

  task automatic check(input string tag, input logic [161:0] obs, input logic [161:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: one training run is EP passes over records 0..n-1
  task automatic plan_train(input int n);
    for (int e = 0; e < EP; e++)
      for (int i = 0; i < n; i++) begin
        int b = 2 + 5 * i;
        bit last = (i == n - 1);
        for (int w = 0; w < 5; w++) exp_addr.push_back(32'(b + w));
        exp_rec.push_back({last, last && (e == EP - 1),
                           mem[b+4], mem[b+3], mem[b+2], mem[b+1], mem[b]});
      end
  endtask

  task automatic plan_test(input int n, input int t);
    int b = 2 + 5 * n + 5 * t;
    for (int w = 0; w < 5; w++) exp_addr.push_back(32'(b + w));
    exp_rec.push_back({1'b1, 1'b1, mem[b+4], mem[b+3], mem[b+2], mem[b+1], mem[b]});
  endtask

  always @(posedge clk) cyc++;

  // memory: random grant wait, in-order returns at least one cycle after grant
  always @(negedge clk) begin
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (rst) begin
      pend.delete();
      outst = 0;
      gwait = 0;
    end else begin
      if (mem_req) begin
        if (gwait > 0) gwait--;
        else begin
          pend_t p;
          mem_gnt = 1'b1;
          gnt_cnt++;
          check("outstanding_limit", 162'((outst + 1) <= MAXO), 162'(1));
          outst++;
          check("req_expected", 162'(exp_addr.size() != 0), 162'(1));
          if (exp_addr.size() != 0) check("mem_addr", 162'(mem_addr), 162'(exp_addr.pop_front()));
          p.addr = mem_addr;
          p.due  = cyc + 2 + ((max_dly > 0) ? int'($urandom_range(max_dly, 0)) : 0);
          pend.push_back(p);
          gwait = (max_dly > 0) ? int'($urandom_range(max_dly, 0)) : 0;
        end
      end
      if (pend.size() != 0 && pend[0].due <= cyc + 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem[pend[0].addr[7:0]];
        void'(pend.pop_front());
        outst--;
      end
    end
  end

  // consumer side: compare every accepted record, and hold-stability under backpressure
  logic [159:0] held;
  bit           hold = 0;
  always @(negedge clk) begin
    if (rst) hold = 0;
    else begin
      if (hold && rec_valid) check("rec_stable", 162'(rec_data), 162'(held));
      hold = rec_valid && !rec_ready;
      held = rec_data;
      if (rec_valid && rec_ready) begin
        pop_cnt++;
        check("rec_expected", 162'(exp_rec.size() != 0), 162'(1));
        if (exp_rec.size() != 0) check("rec", {rec_last, rec_final, rec_data}, exp_rec.pop_front());
      end
    end
  end

  task automatic wait_hdr(input string tag);
    int k = 0;
    while (!hdr_valid && k < 200) begin @(negedge clk); k++; end
    check(tag, 162'(hdr_valid), 162'(1));
  endtask

  task automatic wait_idle(input string tag, input int limit, input bit rnd);
    int k = 0;
    while ((busy || exp_rec.size() != 0) && k < limit) begin
      @(posedge clk); #1;
      if (rnd) rec_ready = 1'($urandom_range(1, 0));
      k++;
    end
    check(tag, {160'(exp_rec.size()), 1'b0, busy}, 162'(0));
    @(posedge clk); #1 rec_ready = 1'b1;
  endtask

  task automatic pulse_train();
    @(posedge clk); #1 start_train = 1'b1;
    @(posedge clk); #1 start_train = 1'b0;
  endtask

  task automatic pulse_test(input logic [7:0] sel);
    @(posedge clk); #1 start_test = 1'b1; test_sel = sel;
    @(posedge clk); #1 start_test = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, p0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'd3;
    mem[1] = 32'd2;

    // reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mem", {mem_req, mem_addr}, 162'(0));
    check("reset_hdr", {hdr_valid, num_train, num_test}, 162'(0));
    check("reset_rec", {rec_valid, rec_last, rec_final, rec_data}, 162'(0));
    check("reset_misc", {busy, sel_err}, 162'(0));

    // header with zero-wait memory
    exp_addr.push_back(32'd0);
    exp_addr.push_back(32'd1);
    @(posedge clk); #1 rst = 1'b0;
    wait_hdr("hdr_valid");
    check("num_train", 162'(num_train), 162'(3));
    check("num_test", 162'(num_test), 162'(2));
    check("hdr_reads", 162'(exp_addr.size()), 162'(0));

    // full training stream, always ready
    @(posedge clk); #1 rec_ready = 1'b1;
    p0 = pop_cnt;
    plan_train(3);
    pulse_train();
    check("busy_train", 162'(busy), 162'(1));
    wait_idle("train_done", 1000, 0);
    check("train_count", 162'(pop_cnt - p0), 162'(6));

    // single test record
    p0 = pop_cnt;
    plan_test(3, 1);
    pulse_test(8'd1);
    check("busy_test", 162'(busy), 162'(1));
    wait_idle("test_done", 500, 0);
    check("test_count", 162'(pop_cnt - p0), 162'(1));

    // backpressure: FIFO fills to DEPTH records and requests stop
    @(posedge clk); #1 rec_ready = 1'b0;
    p0 = pop_cnt;
    g0 = gnt_cnt;
    plan_train(3);
    pulse_train();
    repeat (50) @(negedge clk);
    check("bp_grants", 162'(gnt_cnt - g0), 162'(DEPTH * 5));
    check("bp_req_off", 162'(mem_req), 162'(0));
    check("bp_held", {160'(pop_cnt - p0), rec_valid, busy}, 162'(3));
    @(posedge clk); #1 rec_ready = 1'b1;
    wait_idle("bp_done", 1000, 0);
    check("bp_count", 162'(pop_cnt - p0), 162'(6));

    // out-of-range test select
    pulse_test(8'd2);
    check("sel_err_pulse", {sel_err, busy}, 162'(2));
    @(negedge clk);
    check("sel_err_noreq", 162'(mem_req), 162'(0));
    @(posedge clk); #1;
    check("sel_err_clear", {sel_err, busy, mem_req}, 162'(0));

    // reset in the middle of training, new header afterwards
    mem[0] = 32'd5;
    mem[1] = 32'd4;
    plan_train(3);
    pulse_train();
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_outs", {mem_req, mem_addr, hdr_valid, num_train, num_test, rec_valid, busy}, 162'(0));
    exp_addr.delete();
    exp_rec.delete();
    repeat (2) @(posedge clk);
    exp_addr.push_back(32'd0);
    exp_addr.push_back(32'd1);
    #1 rst = 1'b0;
    wait_hdr("hdr_again");
    check("num_train2", 162'(num_train), 162'(5));
    check("num_test2", 162'(num_test), 162'(4));

    // random memory latency and random consumer readiness
    max_dly = 5;
    for (int i = 2; i < 256; i++) mem[i] = $urandom;
    p0 = pop_cnt;
    plan_train(5);
    pulse_train();
    wait_idle("rand_train_done", 5000, 1);
    check("rand_train_count", 162'(pop_cnt - p0), 162'(5 * EP));
    for (int k = 0; k < 2; k++) begin
      int t = int'($urandom_range(3, 0));
      p0 = pop_cnt;
      plan_test(5, t);
      pulse_test(8'(t));
      wait_idle("rand_test_done", 1000, 1);
      check("rand_test_count", 162'(pop_cnt - p0), 162'(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
